// File: rtl/row_window_buf.sv
// row_window_buf: 3-row vertical window generator for the 3x3 conv PE array.
// Define ROWBUF_PAD_EN for zero-padded frame edges (ROWS windows); undefined gives ROWS-2 windows.
module row_window_buf #(
  parameter int DW    = 32,
  parameter int DEPTH = 56,
  parameter int ROWS  = 56
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW*DEPTH-1:0]   row_i,
  input  logic                  row_valid_i,
  output logic                  row_ready_o,
  output logic [DW*DEPTH-1:0]   win_top_o,
  output logic [DW*DEPTH-1:0]   win_mid_o,
  output logic [DW*DEPTH-1:0]   win_bot_o,
  output logic                  win_valid_o,
  input  logic                  win_ready_i,
  output logic                  win_first_o,
  output logic                  win_last_o
);

  localparam int W = DW * DEPTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t         state_r;
  logic [9:0]     row_cnt_r;
  logic [W-1:0]   r1_r;
  logic [W-1:0]   r2_r;
  logic           slot_free_s;
  logic           row_ready_s;
  logic           accept_s;
  logic           last_row_s;

  assign slot_free_s = !win_valid_o | win_ready_i;
  assign accept_s    = row_valid_i & row_ready_s;
  assign last_row_s  = (row_cnt_r == 10'(ROWS - 1));
  assign row_ready_o = row_ready_s;

  // Upstream may hand over a row whenever the output slot can take the window it triggers.
  always_comb begin
    row_ready_s = 1'b0;
    case (state_r)
      IDLE:    row_ready_s = 1'b1;
      PRIME:   row_ready_s = slot_free_s;
      STREAM:  row_ready_s = slot_free_s;
      FLUSH:   row_ready_s = 1'b0;
      default: row_ready_s = 1'b0;
    endcase
  end

  // Frame FSM, row history and registered window outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      row_cnt_r   <= 10'd0;
      r1_r        <= {W{1'b0}};
      r2_r        <= {W{1'b0}};
      win_top_o   <= {W{1'b0}};
      win_mid_o   <= {W{1'b0}};
      win_bot_o   <= {W{1'b0}};
      win_valid_o <= 1'b0;
      win_first_o <= 1'b0;
      win_last_o  <= 1'b0;
    end else begin
      // A consumed (or empty) slot drops valid unless a new window is loaded below.
      if (win_ready_i) begin
        win_valid_o <= 1'b0;
        win_first_o <= 1'b0;
        win_last_o  <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            r1_r      <= row_i;
            row_cnt_r <= 10'd1;
            state_r   <= PRIME;
          end
        end
        PRIME: begin
          if (accept_s) begin
            r2_r      <= r1_r;
            r1_r      <= row_i;
            row_cnt_r <= 10'd2;
`ifdef ROWBUF_PAD_EN
            win_top_o   <= {W{1'b0}};
            win_mid_o   <= r1_r;
            win_bot_o   <= row_i;
            win_valid_o <= 1'b1;
            win_first_o <= 1'b1;
            win_last_o  <= 1'b0;
            state_r     <= (ROWS == 2) ? FLUSH : STREAM;
`else
            state_r     <= STREAM;
`endif
          end
        end
        STREAM: begin
          if (accept_s) begin
            r2_r        <= r1_r;
            r1_r        <= row_i;
            win_top_o   <= r2_r;
            win_mid_o   <= r1_r;
            win_bot_o   <= row_i;
            win_valid_o <= 1'b1;
`ifdef ROWBUF_PAD_EN
            win_first_o <= 1'b0;
            win_last_o  <= 1'b0;
            state_r     <= last_row_s ? FLUSH : STREAM;
`else
            win_first_o <= (row_cnt_r == 10'd2);
            win_last_o  <= last_row_s;
            state_r     <= last_row_s ? IDLE : STREAM;
`endif
            row_cnt_r   <= row_cnt_r + 10'd1;
          end
        end
        FLUSH: begin
`ifdef ROWBUF_PAD_EN
          if (slot_free_s) begin
            win_top_o   <= r2_r;
            win_mid_o   <= r1_r;
            win_bot_o   <= {W{1'b0}};
            win_valid_o <= 1'b1;
            win_first_o <= 1'b0;
            win_last_o  <= 1'b1;
            state_r     <= IDLE;
          end
`else
          state_r <= IDLE;
`endif
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_window_buf.sv
// Directed bench for row_window_buf (DW=8, DEPTH=4, ROWS=4); row r carries words r+1.
module tb_row_window_buf;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int ROWS  = 4;
  localparam int W     = DW * DEPTH;
`ifdef ROWBUF_PAD_EN
  localparam int NWIN  = 4;
`else
  localparam int NWIN  = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] row_i;
  logic         row_valid_i;
  logic         row_ready_o;
  logic [W-1:0] win_top_o;
  logic [W-1:0] win_mid_o;
  logic [W-1:0] win_bot_o;
  logic         win_valid_o;
  logic         win_ready_i;
  logic         win_first_o;
  logic         win_last_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0] top;
    logic [W-1:0] mid;
    logic [W-1:0] bot;
    logic         first;
    logic         last;
  } win_t;

  win_t q[$];
  logic [W-1:0] exp_top [NWIN];
  logic [W-1:0] exp_mid [NWIN];
  logic [W-1:0] exp_bot [NWIN];
  logic         exp_first [NWIN];
  logic         exp_last [NWIN];

  always #5 clk = ~clk;

  row_window_buf #(.DW(DW), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_i       (row_i),
    .row_valid_i (row_valid_i),
    .row_ready_o (row_ready_o),
    .win_top_o   (win_top_o),
    .win_mid_o   (win_mid_o),
    .win_bot_o   (win_bot_o),
    .win_valid_o (win_valid_o),
    .win_ready_i (win_ready_i),
    .win_first_o (win_first_o),
    .win_last_o  (win_last_o)
  );

  always @(posedge clk) begin
    if (rst_n && win_valid_o && win_ready_i)
      q.push_back({win_top_o, win_mid_o, win_bot_o, win_first_o, win_last_o});
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input int r);
    int n;
    n = 0;
    row_i = {DEPTH{8'(r + 1)}};
    row_valid_i = 1'b1;
    #1;
    while (!row_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("push_row%0d_timeout", r), 32'(n < 50), 32'd1);
    @(negedge clk);
    row_valid_i = 1'b0;
  endtask

  task automatic check_frames(input string tag, input int nf);
    int n;
    int idx;
    n = 0;
    while (q.size() < nf * NWIN && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, 32'(q.size()), 32'(nf * NWIN));
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < NWIN; k++) begin
        idx = f * NWIN + k;
        if (idx < q.size()) begin
          chk($sformatf("%s_f%0d_w%0d_top", tag, f, k), q[idx].top, exp_top[k]);
          chk($sformatf("%s_f%0d_w%0d_mid", tag, f, k), q[idx].mid, exp_mid[k]);
          chk($sformatf("%s_f%0d_w%0d_bot", tag, f, k), q[idx].bot, exp_bot[k]);
          chk($sformatf("%s_f%0d_w%0d_first", tag, f, k), 32'(q[idx].first), 32'(exp_first[k]));
          chk($sformatf("%s_f%0d_w%0d_last", tag, f, k), 32'(q[idx].last), 32'(exp_last[k]));
        end
      end
    end
    chk({tag, "_idle_valid"}, 32'(win_valid_o), 32'd0);
    chk({tag, "_idle_ready"}, 32'(row_ready_o), 32'd1);
    q.delete();
  endtask

  initial begin
    row_i       = 32'h0;
    row_valid_i = 1'b0;
    win_ready_i = 1'b1;
`ifdef ROWBUF_PAD_EN
    exp_top[0] = 32'h00000000; exp_mid[0] = 32'h01010101; exp_bot[0] = 32'h02020202;
    exp_top[1] = 32'h01010101; exp_mid[1] = 32'h02020202; exp_bot[1] = 32'h03030303;
    exp_top[2] = 32'h02020202; exp_mid[2] = 32'h03030303; exp_bot[2] = 32'h04040404;
    exp_top[3] = 32'h03030303; exp_mid[3] = 32'h04040404; exp_bot[3] = 32'h00000000;
    exp_first[0] = 1'b1; exp_first[1] = 1'b0; exp_first[2] = 1'b0; exp_first[3] = 1'b0;
    exp_last[0]  = 1'b0; exp_last[1]  = 1'b0; exp_last[2]  = 1'b0; exp_last[3]  = 1'b1;
`else
    exp_top[0] = 32'h01010101; exp_mid[0] = 32'h02020202; exp_bot[0] = 32'h03030303;
    exp_top[1] = 32'h02020202; exp_mid[1] = 32'h03030303; exp_bot[1] = 32'h04040404;
    exp_first[0] = 1'b1; exp_first[1] = 1'b0;
    exp_last[0]  = 1'b0; exp_last[1]  = 1'b1;
`endif

    // Reset and idle state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_top", win_top_o, 32'h0);
    chk("rst_mid", win_mid_o, 32'h0);
    chk("rst_bot", win_bot_o, 32'h0);
    chk("rst_valid", 32'(win_valid_o), 32'd0);
    chk("rst_first", 32'(win_first_o), 32'd0);
    chk("rst_last", 32'(win_last_o), 32'd0);
    chk("rst_row_ready", 32'(row_ready_o), 32'd1);

    // One frame streamed back-to-back
    for (int r = 0; r < ROWS; r++) push(r);
    check_frames("seq", 1);

    // Backpressure on the first window
    win_ready_i = 1'b0;
    fork
      begin
        for (int r = 0; r < ROWS; r++) push(r);
      end
      begin
        int n;
        n = 0;
        while (!win_valid_o && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        chk("bp_valid", 32'(win_valid_o), 32'd1);
        chk("bp_first", 32'(win_first_o), 32'd1);
        chk("bp_row_ready", 32'(row_ready_o), 32'd0);
        repeat (5) @(negedge clk);
        chk("bp_hold_top", win_top_o, exp_top[0]);
        chk("bp_hold_mid", win_mid_o, exp_mid[0]);
        chk("bp_hold_bot", win_bot_o, exp_bot[0]);
        chk("bp_hold_valid", 32'(win_valid_o), 32'd1);
        chk("bp_hold_row_ready", 32'(row_ready_o), 32'd0);
        win_ready_i = 1'b1;
      end
    join
    check_frames("bp", 1);

    // Two frames with no gap
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < ROWS; r++) push(r);
    check_frames("two", 2);

    // Asynchronous reset mid-frame
    for (int r = 0; r < 3; r++) push(r);
    @(negedge clk);
    chk("prerst_mid", win_mid_o, 32'h02020202);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_top", win_top_o, 32'h0);
    chk("arst_mid", win_mid_o, 32'h0);
    chk("arst_bot", win_bot_o, 32'h0);
    chk("arst_valid", 32'(win_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) push(r);
    check_frames("rst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
